bsg_bypass_reg_rr_ctrl: RTL and testbench
=========================================

// Module: bsg_bypass_reg_rr_ctrl
//
// PURPOSE
//   Round-robin scheduler that shares one enable-bypass holding register between
//   els_p requesters and one downstream consumer.
//   - When the register is empty, the granted input is bypassed straight to the output.
//   - If the consumer stalls, the granted word is captured and replayed from the
//     register until it is taken.
//   - Sits between N producer ports and a single-lane consumer. This is the
//     sequencer for the en/bypass register datapath.
//
// PARAMETERS
//   els_p        4    number of requesters (>=1)
//   width_p      16   data width per requester
//   id_width_lp  -    localparam = (els_p==1) ? 1 : $clog2(els_p)
//
// PORTS
//   clk_i        in   1                single clock, posedge
//   reset_i      in   1                synchronous, active-high reset
//   v_i          in   els_p            per-requester valid
//   data_i       in   els_p*width_p    requester k occupies bits [k*width_p +: width_p]
//   yumi_o       out  els_p            one-hot; requester k's word is consumed this cycle
//   v_o          out  1                output valid
//   data_o       out  width_p          output data
//   grant_id_o   out  id_width_lp      index of requester owning data_o
//   ready_i      in   1                consumer accepts data_o when v_o & ready_i
//   stall_cnt_o  out  16               present only with BSG_BYPASS_RR_STALL_CNT_EN
//
// BEHAVIOUR
//   State and pointer
//   - Two-state FSM: EMPTY, FULL. Reset -> EMPTY.
//   - Reset values: rr_ptr=0, stall count=0, holding register contents don't-care.
//   - Output gating: v_o=0, yumi_o=0, data_o=0 and grant_id_o=0 whenever v_o=0.
//   - Arbitration: sel = first k with v_i[k]=1, scanning rr_ptr, rr_ptr+1, ...
//     with wrap mod els_p.
//   EMPTY, no v_i
//   - v_o=0, all outputs 0, no state change.
//   EMPTY, any v_i
//   - v_o=1, data_o = data_i[sel] (combinational bypass), grant_id_o=sel.
//   - yumi_o[sel]=1 regardless of ready_i. No combinational path ready_i -> yumi_o.
//   - rr_ptr <= (sel+1) mod els_p.
//   - ready_i=1: stay EMPTY. Latency 0 cycles input-to-output.
//   - ready_i=0: reg <= data_i[sel] (en=1), id_r <= sel, go FULL.
//   FULL
//   - v_o=1, data_o=reg, grant_id_o=id_r, yumi_o=0.
//   - New requests wait and the register is not rewritten.
//   - ready_i=1: go EMPTY. The next grant appears the following cycle
//     (one bubble-free handoff is not required).
//   Boundary cases
//   - Back-to-back streaming with ready_i held high gives 1 word/cycle, rotating
//     fairly among all valid requesters.
//   - els_p=1: rr_ptr is constant 0, sel=0 whenever v_i[0].
//   - A requester may drop v_i while FULL. That has no effect on the held word.
//   - Reset asserted while FULL discards the held word. It must not be re-presented.
//   - reset_i dominates all other inputs in the same cycle.
//   - Inputs are sampled only while EMPTY. data_i of non-selected requesters is ignored.
//
// CONFIGURATION
//   BSG_BYPASS_RR_STALL_CNT_EN
//   - Defined: adds port stall_cnt_o[15:0], a saturating count of cycles with
//     v_o=1 & ready_i=0.
//     - Cleared by reset_i.
//     - Holds at 16'hFFFF.
//     - Registered, so the update is visible the next cycle.
//   - Undefined: port and counter are absent. All other behaviour is identical.
//
// TESTING
//   1. Reset, v_i=0 -> v_o=0, yumi_o=0, data_o=0 for 10 cycles. Reset mid-FULL
//      -> v_o=0 the next cycle.
//   2. els_p=4, ready_i=1, v_i=4'b1111, data_i[k]=16'h00A0+k -> data_o sequence
//      A0,A1,A2,A3,A0. yumi_o one-hot rotating. Zero-cycle bypass.
//   3. v_i=4'b0100, data 16'hBEEF, ready_i=0 -> yumi_o=4'b0100 once, FSM FULL.
//      data_o=BEEF held while data_i changes. ready_i=1 -> EMPTY.
//   4. FULL holding requester 1, v_i=4'b1011 for 3 stall cycles -> yumi_o=0
//      throughout. After release, next grant=3 (rr_ptr=2, no v_i[2]).
//   5. els_p=1, v_i toggling, ready_i random -> data order preserved, never a
//      duplicate or lost word (scoreboard).
//   6. With BSG_BYPASS_RR_STALL_CNT_EN: 5 stall cycles -> stall_cnt_o=5.
//      Force 70000 stalls -> stall_cnt_o=16'hFFFF.

Source files
------------

// File: rtl/bsg_bypass_reg_rr_ctrl.sv
// rtl/bsg_bypass_reg_rr_ctrl.sv - round-robin sequencer for a shared enable/bypass holding register
// Optional stall counter port enabled by BSG_BYPASS_RR_STALL_CNT_EN.
module bsg_bypass_reg_rr_ctrl #(
    parameter int els_p   = 4,
    parameter int width_p = 16,
    localparam int id_width_lp = (els_p == 1) ? 1 : $clog2(els_p)
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic [els_p-1:0]           v_i,
    input  logic [els_p*width_p-1:0]   data_i,
    output logic [els_p-1:0]           yumi_o,
    output logic                       v_o,
    output logic [width_p-1:0]         data_o,
    output logic [id_width_lp-1:0]     grant_id_o,
    input  logic                       ready_i
`ifdef BSG_BYPASS_RR_STALL_CNT_EN
    ,output logic [15:0]               stall_cnt_o
`endif
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

    localparam int ext_lp = 2 ** id_width_lp;

    state_e                  state_r, state_n;
    logic [id_width_lp-1:0]  rr_ptr_r;
    logic [id_width_lp-1:0]  id_r;
    logic [width_p-1:0]      data_r;
    logic [id_width_lp-1:0]  sel;
    logic [id_width_lp:0]    idx;
    logic                    any_v;
    logic [width_p-1:0]      sel_data;
    logic [ext_lp-1:0]       v_ext;

    assign v_ext = ext_lp'(v_i);

    // Scan rr_ptr, rr_ptr+1, ... with wrap; first valid requester wins.
    always_comb begin
        any_v = 1'b0;
        sel   = '0;
        idx   = '0;
        for (int i = 0; i < els_p; i++) begin
            idx = {1'b0, rr_ptr_r} + (id_width_lp+1)'(i);
            if (idx >= (id_width_lp+1)'(els_p))
                idx = idx - (id_width_lp+1)'(els_p);
            if (!any_v && v_ext[idx[id_width_lp-1:0]]) begin
                any_v = 1'b1;
                sel   = idx[id_width_lp-1:0];
            end
        end
    end

    always_comb begin
        sel_data = '0;
        for (int k = 0; k < els_p; k++) begin
            if (sel == id_width_lp'(k))
                sel_data = data_i[k*width_p +: width_p];
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r  <= EMPTY;
            rr_ptr_r <= '0;
        end else begin
            state_r <= state_n;
            if (state_r == EMPTY && any_v)
                rr_ptr_r <= (sel == id_width_lp'(els_p - 1)) ? '0 : sel + id_width_lp'(1);
        end
    end

    // Capture only when a bypassed word is not taken by the consumer.
    always_ff @(posedge clk_i) begin
        if (!reset_i && state_r == EMPTY && any_v && !ready_i) begin
            data_r <= sel_data;
            id_r   <= sel;
        end
    end

    always_comb begin
        state_n = state_r;
        case (state_r)
            EMPTY:   if (any_v && !ready_i) state_n = FULL;
            FULL:    if (ready_i)           state_n = EMPTY;
            default: state_n = EMPTY;
        endcase
    end

    // Outputs are gated while reset is asserted so a discarded word never leaks out.
    always_comb begin
        v_o        = 1'b0;
        yumi_o     = '0;
        data_o     = '0;
        grant_id_o = '0;
        if (!reset_i) begin
            case (state_r)
                EMPTY: begin
                    if (any_v) begin
                        v_o        = 1'b1;
                        yumi_o     = els_p'(1'b1) << sel;
                        data_o     = sel_data;
                        grant_id_o = sel;
                    end
                end
                FULL: begin
                    v_o        = 1'b1;
                    data_o     = data_r;
                    grant_id_o = id_r;
                end
                default: ;
            endcase
        end
    end

`ifdef BSG_BYPASS_RR_STALL_CNT_EN
    logic [15:0] stall_cnt_r;

    always_ff @(posedge clk_i) begin
        if (reset_i)
            stall_cnt_r <= '0;
        else if (v_o && !ready_i && stall_cnt_r != 16'hFFFF)
            stall_cnt_r <= stall_cnt_r + 16'd1;
    end

    assign stall_cnt_o = stall_cnt_r;
`endif

endmodule

// File: tb/tb_bsg_bypass_reg_rr_ctrl.sv
// tb/tb_bsg_bypass_reg_rr_ctrl.sv - bench for bsg_bypass_reg_rr_ctrl
module tb_bsg_bypass_reg_rr_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, rdy, vo;
    logic [3:0]  v, yumi;
    logic [63:0] d;
    logic [15:0] dout;
    logic [1:0]  gid;

    logic        rst1, rdy1, vo1;
    logic [0:0]  v1, yumi1, gid1;
    logic [15:0] d1, dout1;

`ifdef BSG_BYPASS_RR_STALL_CNT_EN
    logic [15:0] scnt, scnt1;
`endif

    bsg_bypass_reg_rr_ctrl #(.els_p(4), .width_p(16)) u_dut (
        .clk_i(clk), .reset_i(rst), .v_i(v), .data_i(d), .yumi_o(yumi),
        .v_o(vo), .data_o(dout), .grant_id_o(gid), .ready_i(rdy)
`ifdef BSG_BYPASS_RR_STALL_CNT_EN
        , .stall_cnt_o(scnt)
`endif
    );

    bsg_bypass_reg_rr_ctrl #(.els_p(1), .width_p(16)) u_dut1 (
        .clk_i(clk), .reset_i(rst1), .v_i(v1), .data_i(d1), .yumi_o(yumi1),
        .v_o(vo1), .data_o(dout1), .grant_id_o(gid1), .ready_i(rdy1)
`ifdef BSG_BYPASS_RR_STALL_CNT_EN
        , .stall_cnt_o(scnt1)
`endif
    );

    typedef struct {
        string       nm;
        logic        rst;
        logic [3:0]  v;
        logic [63:0] d;
        logic        rdy;
        logic        ev;
        logic [3:0]  ey;
        logic [15:0] ed;
        logic [1:0]  eid;
    } vec_t;

    vec_t vq[$];
    int n_vec = 0;
    int n_bad = 0;

    function automatic logic [63:0] pk(input logic [15:0] a0, a1, a2, a3);
        return {a3, a2, a1, a0};
    endfunction

    function automatic vec_t mk(input string nm, input logic r, input logic [3:0] vv,
                                input logic [63:0] dd, input logic rd, input logic ev,
                                input logic [3:0] ey, input logic [15:0] ed, input logic [1:0] eid);
        vec_t t;
        t.nm = nm; t.rst = r; t.v = vv; t.d = dd; t.rdy = rd;
        t.ev = ev; t.ey = ey; t.ed = ed; t.eid = eid;
        return t;
    endfunction

    task automatic check(input string nm, input logic ev, input logic [3:0] ey,
                         input logic [15:0] ed, input logic [1:0] eid);
        n_vec++;
        if (vo !== ev || yumi !== ey || dout !== ed || gid !== eid) begin
            n_bad++;
            $display("FAIL %s: got v=%0b yumi=%b data=%h id=%0d, want v=%0b yumi=%b data=%h id=%0d",
                     nm, vo, yumi, dout, gid, ev, ey, ed, eid);
        end
    endtask

    task automatic drive(input logic r, input logic [3:0] vv, input logic [63:0] dd, input logic rd);
        @(posedge clk);
        #1;
        rst = r; v = vv; d = dd; rdy = rd;
    endtask

    // Reference state: held word flag/contents and round-robin pointer.
    int          m_held, m_id, m_ptr, sel;
    logic [15:0] m_data;
    logic        ev;
    logic [3:0]  ey;
    logic [15:0] ed, exp1;
    logic [1:0]  eid;
    logic [15:0] sbq[$];
    logic [15:0] nxt;

    initial begin
        rst = 1'b1; v = '0; d = '0; rdy = 1'b0;
        rst1 = 1'b1; v1 = '0; d1 = '0; rdy1 = 1'b0;

        for (int i = 0; i < 10; i++)
            vq.push_back(mk("reset_idle", 1, 4'b0000, '0, 0, 0, 4'b0000, 16'h0, 0));
        vq.push_back(mk("idle", 0, 4'b0000, pk(16'h1, 16'h2, 16'h3, 16'h4), 1, 0, 4'b0000, 16'h0, 0));
        for (int i = 0; i < 5; i++)
            vq.push_back(mk("stream", 0, 4'b1111, pk(16'h00A0, 16'h00A1, 16'h00A2, 16'h00A3), 1,
                            1, 4'(1 << (i % 4)), 16'(16'h00A0 + i % 4), 2'(i % 4)));
        vq.push_back(mk("beef_grant", 0, 4'b0100, pk(0, 0, 16'hBEEF, 0), 0, 1, 4'b0100, 16'hBEEF, 2));
        vq.push_back(mk("beef_hold", 0, 4'b0100, pk(0, 0, 16'h1234, 0), 0, 1, 4'b0000, 16'hBEEF, 2));
        vq.push_back(mk("beef_release", 0, 4'b0100, pk(0, 0, 16'h5678, 0), 1, 1, 4'b0000, 16'hBEEF, 2));
        vq.push_back(mk("after_release", 0, 4'b0000, '0, 1, 0, 4'b0000, 16'h0, 0));
        vq.push_back(mk("req1_grant", 0, 4'b0010, pk(0, 16'h1111, 0, 0), 0, 1, 4'b0010, 16'h1111, 1));
        for (int i = 0; i < 3; i++)
            vq.push_back(mk("req1_stall", 0, 4'b1011, pk(16'hC0, 16'hC1, 16'hC2, 16'h3333), 0,
                            1, 4'b0000, 16'h1111, 1));
        vq.push_back(mk("req1_release", 0, 4'b1011, pk(16'hC0, 16'hC1, 16'hC2, 16'h3333), 1,
                        1, 4'b0000, 16'h1111, 1));
        vq.push_back(mk("next_grant3", 0, 4'b1011, pk(16'hC0, 16'hC1, 16'hC2, 16'h3333), 1,
                        1, 4'b1000, 16'h3333, 3));
        vq.push_back(mk("fill_for_reset", 0, 4'b0001, pk(16'h5555, 0, 0, 0), 0, 1, 4'b0001, 16'h5555, 0));
        vq.push_back(mk("reset_full", 1, 4'b0000, '0, 0, 0, 4'b0000, 16'h0, 0));
        vq.push_back(mk("no_replay", 0, 4'b0000, '0, 1, 0, 4'b0000, 16'h0, 0));

        foreach (vq[i]) begin
            drive(vq[i].rst, vq[i].v, vq[i].d, vq[i].rdy);
            @(negedge clk);
            check(vq[i].nm, vq[i].ev, vq[i].ey, vq[i].ed, vq[i].eid);
        end

        m_held = 0; m_ptr = 0; m_id = 0; m_data = '0;
        for (int i = 0; i < 400; i++) begin
            drive((i == 0) || ($urandom_range(0, 39) == 0), 4'($urandom), {$urandom, $urandom},
                  $urandom_range(0, 2) != 0);
            ev = 0; ey = '0; ed = '0; eid = '0; sel = -1;
            if (!rst) begin
                if (m_held != 0) begin
                    ev = 1; ed = m_data; eid = 2'(m_id);
                end else begin
                    for (int o = 0; o < 4; o++)
                        if (sel < 0 && v[(m_ptr + o) % 4]) sel = (m_ptr + o) % 4;
                    if (sel >= 0) begin
                        ev = 1; ed = d[sel*16 +: 16]; ey = 4'(1 << sel); eid = 2'(sel);
                    end
                end
            end
            @(negedge clk);
            check("random", ev, ey, ed, eid);
            if (rst) begin
                m_held = 0; m_ptr = 0;
            end else if (m_held != 0) begin
                if (rdy) m_held = 0;
            end else if (sel >= 0) begin
                m_ptr = (sel + 1) % 4;
                if (!rdy) begin m_held = 1; m_data = ed; m_id = sel; end
            end
        end

        nxt = 16'h1000;
        @(posedge clk);
        for (int i = 0; i < 303; i++) begin
            @(posedge clk);
            #1;
            rst1 = 1'b0;
            d1 = nxt;
            if (i < 300) begin v1 = 1'($urandom); rdy1 = 1'($urandom); end
            else begin v1 = 1'b0; rdy1 = 1'b1; end
            @(negedge clk);
            if (yumi1[0]) begin sbq.push_back(d1); nxt = nxt + 16'd1; end
            if (vo1 && rdy1) begin
                n_vec++;
                if (sbq.size() == 0) begin
                    n_bad++;
                    $display("FAIL sb_underflow: got data=%h with no pending word", dout1);
                end else begin
                    exp1 = sbq.pop_front();
                    if (dout1 !== exp1 || gid1 !== 1'b0) begin
                        n_bad++;
                        $display("FAIL sb_order: got data=%h id=%0d, want data=%h id=0", dout1, gid1, exp1);
                    end
                end
            end
        end
        n_vec++;
        if (sbq.size() != 0 || nxt == 16'h1000) begin
            n_bad++;
            $display("FAIL sb_drain: got %0d words pending, %0d accepted, want 0 pending and >0 accepted",
                     sbq.size(), nxt - 16'h1000);
        end

`ifdef BSG_BYPASS_RR_STALL_CNT_EN
        drive(1, 4'b0000, '0, 0);
        for (int i = 0; i < 6; i++) drive(0, 4'b0001, pk(16'h77, 0, 0, 0), 0);
        @(negedge clk);
        n_vec++;
        if (scnt !== 16'd5) begin
            n_bad++;
            $display("FAIL stall_cnt_5: got %0d, want 5", scnt);
        end
        repeat (70000) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (scnt !== 16'hFFFF) begin
            n_bad++;
            $display("FAIL stall_cnt_sat: got %h, want ffff", scnt);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
